data_mem_responder: RTL



---
 rtl/data_mem_responder_pkg.sv | 12 +
 rtl/data_mem_responder_array.sv | 24 ++
 rtl/data_mem_responder.sv | 130 +++++++++++++
 3 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared widths and FSM state encoding for the data-memory responder.
package data_mem_responder_pkg;
    localparam int DMEM_ADDR_W = 7;
    localparam int DMEM_DATA_W = 32;
    localparam int DMEM_DEPTH  = 128;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_SERVE = 2'd1,
        ST_LOAD  = 2'd2
    } dmem_state_e;
endpackage

// File: rtl/data_mem_responder_array.sv
// Word storage: one synchronous write port, one asynchronous read port.
module dmem_array #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 128
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem_r [DEPTH];

    // Commit the selected write on the rising edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];
endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: core port with zero-latency reads, reset clear sweep,
// valid/ready backdoor loader and sticky not-ready access flag.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int ADDR_W         = DMEM_ADDR_W,
    parameter int DATA_W         = DMEM_DATA_W,
    parameter int DEPTH          = DMEM_DEPTH,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              CEN,
    input  logic              WEN,
    input  logic              OEN,
    input  logic [ADDR_W-1:0] A,
    input  logic [DATA_W-1:0] Data2Mem,
    output logic [DATA_W-1:0] ReadDataMem,
    output logic              mem_ready,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic [ADDR_W:0]   ld_count,
    output logic              acc_err
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   COUNT_MAX = (ADDR_W + 1)'(DEPTH);

    dmem_state_e       state_r, state_nxt_s;
    logic [ADDR_W-1:0] clr_ptr_r;
    logic [ADDR_W:0]   ld_count_r;
    logic              acc_err_r;
    logic              we_s;
    logic [ADDR_W-1:0] waddr_s;
    logic [DATA_W-1:0] wdata_s;
    logic [DATA_W-1:0] rdata_s;
    logic [DATA_W-1:0] read_s;

    dmem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (we_s),
        .waddr (waddr_s),
        .wdata (wdata_s),
        .raddr (A),
        .rdata (rdata_s)
    );

    // Next-state logic, write-port mux and read gating.
    always_comb begin
        state_nxt_s = state_r;
        we_s        = 1'b0;
        waddr_s     = A;
        wdata_s     = Data2Mem;
        read_s      = '0;
        case (state_r)
            ST_CLEAR: begin
                we_s    = 1'b1;
                waddr_s = clr_ptr_r;
                wdata_s = '0;
                if (clr_ptr_r == LAST_ADDR) begin
                    state_nxt_s = ST_SERVE;
                end else begin
                    state_nxt_s = ST_CLEAR;
                end
            end
            ST_SERVE: begin
                we_s = ~CEN & ~WEN;
                if (~CEN & ~OEN) begin
                    read_s = rdata_s;
                end else begin
                    read_s = '0;
                end
                // The core has priority: the loader only gets in on idle cycles.
                if (ld_valid & CEN) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_SERVE;
                end
            end
            ST_LOAD: begin
                we_s    = ld_valid;
                waddr_s = ld_addr;
                wdata_s = ld_data;
                if (ld_valid & ld_last) begin
                    state_nxt_s = ST_SERVE;
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            default: begin
                state_nxt_s = ST_SERVE;
            end
        endcase
    end

    // State, clear pointer, loader count and sticky error registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_SERVE;
            clr_ptr_r  <= '0;
            ld_count_r <= '0;
            acc_err_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (state_r == ST_CLEAR) begin
                clr_ptr_r <= clr_ptr_r + 1'b1;
            end
            if ((state_r == ST_SERVE) && (state_nxt_s == ST_LOAD)) begin
                ld_count_r <= '0;
            end else if ((state_r == ST_LOAD) && ld_valid && (ld_count_r != COUNT_MAX)) begin
                ld_count_r <= ld_count_r + 1'b1;
            end
            if (~CEN && (state_r != ST_SERVE)) begin
                acc_err_r <= 1'b1;
            end
        end
    end

    assign ReadDataMem = read_s;
    assign mem_ready   = (state_r == ST_SERVE);
    assign ld_ready    = (state_r == ST_LOAD);
    assign ld_count    = ld_count_r;
    assign acc_err     = acc_err_r;
endmodule
